battle_damage_scheduler: RTL and testbench
==========================================

Name: battle_damage_scheduler

Overview:
- Turn-level scheduler that shares one multiply/add damage pipeline between two requesters: the player attack path and the AI attack path.
- Arbitrates between them round-robin and sequences the damage calculation: multiply, add bonus, subtract from the target's HP.
- Holds both HP registers and raises victory/loss when an HP reaches zero.
- Sits between the turn-control FSM (the requesters) and the HP/display logic.

Parameters:
W, 8, data width of stats, power, damage and HP
HP_INIT, 100, HP loaded into both HP registers on reset
DMG_BONUS, 2, constant added to every raw damage product

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to reset state
req_p  in  1  player attack request, level, held until gnt_p
atk_p  in  W  player attack stat
pow_p  in  W  player move power
req_a  in  1  AI attack request, level, held until gnt_a
atk_a  in  W  AI attack stat
pow_a  in  W  AI move power
gnt_p  out  1  one-cycle pulse: player request accepted
gnt_a  out  1  one-cycle pulse: AI request accepted
busy  out  1  high whenever state is not IDLE or END
done  out  1  one-cycle pulse: damage applied, dmg_out valid
dmg_out  out  W  damage from last completed calculation, held until next done
hp_p  out  W  player HP
hp_a  out  W  AI HP
hp_is_zero  out  1  hp_p==0 or hp_a==0
victory  out  1  sticky: hp_a reached 0
loss  out  1  sticky: hp_p reached 0

Behaviour:
- Reset values:
  - hp_p = hp_a = HP_INIT.
  - gnt_p, gnt_a, busy, done, dmg_out, victory, loss = 0; hp_is_zero = 0.
  - State = IDLE; last-served = AI, so the player wins the first tie.
- Reset asserted mid-operation aborts the calculation: no done, no HP change; reset values apply on the next cycle.
- All outputs are registered.

State machine:
- IDLE:
  - On an edge with any request, select the winner and latch its atk/pow and target. Target is AI for player requests, player for AI requests.
  - Go to MUL.
  - Winner is the sole requester; if both request, the one not last served wins; last-served is then updated.
- MUL:
  - gnt_x of the winner is high for exactly this cycle.
  - prod = atk*pow at 2W bits; if it exceeds 2^W-1, saturate to 2^W-1.
  - Go to ADD.
- ADD:
  - dmg = prod + DMG_BONUS, saturating at 2^W-1.
  - Go to APPLY.
- APPLY:
  - target HP = HP - dmg, clamping at 0 (no wrap).
  - Go to DONE.
- DONE:
  - done = 1 and dmg_out = dmg.
  - If hp_a==0, set victory and go to END.
  - Else if hp_p==0, set loss and go to END.
  - Else go to IDLE.
- END:
  - Terminal state; requests are ignored, no grants.
  - victory/loss/hp_is_zero hold until reset.

Timing and handshake:
- Latency: request sampled at edge 0; gnt at cycle 1; done at cycle 4; back to IDLE at cycle 5.
- A request still high after its grant pulse is treated as a new request.
- Requests arriving while busy wait; they are sampled on the first IDLE cycle.
- Only the target HP changes per calculation. Zero damage is impossible when DMG_BONUS > 0.

Optional Feature:
- Macro: PBS_CRIT_EN.
- With the macro:
  - Adds inputs crit_p and crit_a (1 bit each), latched with the operands.
  - If the latched crit is set, ADD computes dmg = 2*(prod + DMG_BONUS), saturating at 2^W-1.
- Without the macro: the ports do not exist and no doubling occurs.

Test Plan:
- reset; req_p=1, atk_p=5, pow_p=4 -> gnt_p at cycle 1, done at cycle 4, dmg_out=22, hp_a=78, hp_p=100, busy high for cycles 1-4.
- After reset, req_p and req_a both high; atk_p=5, pow_p=4, atk_a=3, pow_a=3 -> player served first (hp_a=78); after IDLE, AI served (dmg_out=11, hp_p=89); gnt_p and gnt_a never high together.
- req_p with atk_p=20, pow_p=20 -> product 400 saturates to 255, +2 stays 255; hp_a=0, victory=1, hp_is_zero=1 at done; a later req_a gives no gnt_a and busy=0.
- Drive hp_p down to 5 with AI hits, then AI hit of 11 -> hp_p=0 (clamped, no wrap), loss=1, victory=0.
- reset asserted in the ADD cycle of a player hit -> next cycle hp_a=100, done=0, state IDLE; a fresh req_p completes normally.
- With PBS_CRIT_EN: req_p, crit_p=1, atk_p=5, pow_p=4 -> dmg_out=44, hp_a=56; with crit_p=0 -> dmg_out=22.

Source files
------------

// File: rtl/battle_damage_scheduler.sv
// Round-robin scheduler sharing one multiply/add damage pipeline between player and AI.
// Optional critical-hit doubling is enabled by defining PBS_CRIT_EN.
module battle_damage_scheduler #(
   parameter int unsigned W         = 8,
   parameter int unsigned HP_INIT   = 100,
   parameter int unsigned DMG_BONUS = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_p,
   input  logic [W-1:0] atk_p,
   input  logic [W-1:0] pow_p,
   input  logic         req_a,
   input  logic [W-1:0] atk_a,
   input  logic [W-1:0] pow_a,
`ifdef PBS_CRIT_EN
   input  logic         crit_p,
   input  logic         crit_a,
`endif
   output logic         gnt_p,
   output logic         gnt_a,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] dmg_out,
   output logic [W-1:0] hp_p,
   output logic [W-1:0] hp_a,
   output logic         hp_is_zero,
   output logic         victory,
   output logic         loss
);

   localparam int unsigned XW = 2*W + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_ADD,
      S_APPLY,
      S_DONE,
      S_END
   } state_t;

   state_t state, state_next;

   logic [W-1:0]    op_atk, op_pow;
   logic            tgt_a;
   logic            last_a;
   logic [W-1:0]    prod, dmg;
   logic            sel_p, sel_a;
   logic [2*W-1:0]  prod_full;
   logic [W-1:0]    prod_sat;
   logic [XW-1:0]   sum_x;
   logic [W-1:0]    dmg_calc;
   logic [W-1:0]    hp_tgt, hp_new, hp_other;
`ifdef PBS_CRIT_EN
   logic            crit_l;
`endif

   // Player wins a tie only when the AI was served last.
   always_comb begin
      sel_p = req_p && (!req_a || last_a);
      sel_a = req_a && !sel_p;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (req_p || req_a) state_next = S_MUL;
         S_MUL:   state_next = S_ADD;
         S_ADD:   state_next = S_APPLY;
         S_APPLY: state_next = S_DONE;
         S_DONE:  state_next = (victory || loss) ? S_END : S_IDLE;
         S_END:   state_next = S_END;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      prod_full = {{W{1'b0}}, op_atk} * {{W{1'b0}}, op_pow};
      prod_sat  = (prod_full[2*W-1:W] != '0) ? '1 : prod_full[W-1:0];

      sum_x = XW'(prod) + XW'(DMG_BONUS);
`ifdef PBS_CRIT_EN
      if (crit_l)
         sum_x = sum_x << 1;
`endif
      dmg_calc = (sum_x > XW'({W{1'b1}})) ? '1 : sum_x[W-1:0];

      hp_tgt   = tgt_a ? hp_a : hp_p;
      hp_other = tgt_a ? hp_p : hp_a;
      hp_new   = (hp_tgt > dmg) ? (hp_tgt - dmg) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_a     <= 1'b1;
         op_atk     <= '0;
         op_pow     <= '0;
         tgt_a      <= 1'b0;
         prod       <= '0;
         dmg        <= '0;
         gnt_p      <= 1'b0;
         gnt_a      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dmg_out    <= '0;
         hp_p       <= W'(HP_INIT);
         hp_a       <= W'(HP_INIT);
         hp_is_zero <= 1'b0;
         victory    <= 1'b0;
         loss       <= 1'b0;
`ifdef PBS_CRIT_EN
         crit_l     <= 1'b0;
`endif
      end else begin
         state <= state_next;
         gnt_p <= (state == S_IDLE) && sel_p;
         gnt_a <= (state == S_IDLE) && sel_a;
         busy  <= (state_next != S_IDLE) && (state_next != S_END);
         done  <= (state == S_APPLY);

         if (state == S_IDLE && (req_p || req_a)) begin
            op_atk <= sel_p ? atk_p : atk_a;
            op_pow <= sel_p ? pow_p : pow_a;
            tgt_a  <= sel_p;
            last_a <= sel_a;
`ifdef PBS_CRIT_EN
            crit_l <= sel_p ? crit_p : crit_a;
`endif
         end

         if (state == S_MUL)
            prod <= prod_sat;
         if (state == S_ADD)
            dmg <= dmg_calc;

         // HP and end flags are registered together with done so they are valid in the done cycle.
         if (state == S_APPLY) begin
            dmg_out <= dmg;
            if (tgt_a)
               hp_a <= hp_new;
            else
               hp_p <= hp_new;
            victory    <= victory | (tgt_a && (hp_new == '0));
            loss       <= loss | (!tgt_a && (hp_new == '0));
            hp_is_zero <= (hp_new == '0) || (hp_other == '0);
         end
      end
   end

endmodule

// File: tb/tb_battle_damage_scheduler.sv
// Directed self-checking bench for battle_damage_scheduler (crit cases under PBS_CRIT_EN).
module tb_battle_damage_scheduler;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_p = 1'b0, req_a = 1'b0;
   logic [W-1:0] atk_p = '0, pow_p = '0, atk_a = '0, pow_a = '0;
`ifdef PBS_CRIT_EN
   logic         crit_p = 1'b0, crit_a = 1'b0;
`endif
   logic         gnt_p, gnt_a, busy, done, hp_is_zero, victory, loss;
   logic [W-1:0] dmg_out, hp_p, hp_a;

   int checks = 0;
   int failures = 0;

   battle_damage_scheduler #(.W(W), .HP_INIT(100), .DMG_BONUS(2)) dut (
      .clk(clk), .reset(reset),
      .req_p(req_p), .atk_p(atk_p), .pow_p(pow_p),
      .req_a(req_a), .atk_a(atk_a), .pow_a(pow_a),
`ifdef PBS_CRIT_EN
      .crit_p(crit_p), .crit_a(crit_a),
`endif
      .gnt_p(gnt_p), .gnt_a(gnt_a), .busy(busy), .done(done),
      .dmg_out(dmg_out), .hp_p(hp_p), .hp_a(hp_a),
      .hp_is_zero(hp_is_zero), .victory(victory), .loss(loss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("gnt_exclusive", {31'd0, gnt_p & gnt_a}, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_p = 1'b0;
      req_a = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Issue one request, drop it after the grant, return in the done cycle.
   task automatic run_hit(input logic ai, input logic [W-1:0] atk, input logic [W-1:0] pow);
      bit seen;
      if (ai) begin req_a = 1'b1; atk_a = atk; pow_a = pow; end
      else    begin req_p = 1'b1; atk_p = atk; pow_p = pow; end
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (ai ? gnt_a : gnt_p) seen = 1;
      end
      chk("grant_seen", {31'd0, seen}, 1);
      req_a = 1'b0;
      req_p = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (done) seen = 1;
      end
      chk("done_seen", {31'd0, seen}, 1);
   endtask

   initial begin
      // Reset values
      do_reset();
      chk("rst_hp_p", hp_p, 100);
      chk("rst_hp_a", hp_a, 100);
      chk("rst_gnt", {30'd0, gnt_p, gnt_a}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dmg", dmg_out, 0);
      chk("rst_flags", {29'd0, victory, loss, hp_is_zero}, 0);

      // Single player hit: 5*4+2 = 22
      req_p = 1'b1; atk_p = 8'd5; pow_p = 8'd4;
      tick();
      chk("t1_c1_gnt_p", gnt_p, 1);
      chk("t1_c1_busy", busy, 1);
      req_p = 1'b0;
      tick();
      chk("t1_c2_gnt_p", gnt_p, 0);
      chk("t1_c2_busy", busy, 1);
      tick();
      chk("t1_c3_done", done, 0);
      chk("t1_c3_hp_a", hp_a, 100);
      chk("t1_c3_busy", busy, 1);
      tick();
      chk("t1_c4_done", done, 1);
      chk("t1_c4_dmg", dmg_out, 22);
      chk("t1_c4_hp_a", hp_a, 78);
      chk("t1_c4_hp_p", hp_p, 100);
      chk("t1_c4_busy", busy, 1);
      tick();
      chk("t1_c5_done", done, 0);
      chk("t1_c5_busy", busy, 0);
      chk("t1_c5_dmg_hold", dmg_out, 22);

      // Both requesting: player first, then AI by round robin
      do_reset();
      req_p = 1'b1; atk_p = 8'd5; pow_p = 8'd4;
      req_a = 1'b1; atk_a = 8'd3; pow_a = 8'd3;
      tick();
      chk("t2_c1_gnt_p", gnt_p, 1);
      chk("t2_c1_gnt_a", gnt_a, 0);
      tick(); tick(); tick();
      chk("t2_c4_done", done, 1);
      chk("t2_c4_hp_a", hp_a, 78);
      tick();
      chk("t2_c5_gnt_a", gnt_a, 0);
      tick();
      chk("t2_c6_gnt_a", gnt_a, 1);
      chk("t2_c6_gnt_p", gnt_p, 0);
      req_p = 1'b0; req_a = 1'b0;
      tick(); tick(); tick();
      chk("t2_c9_done", done, 1);
      chk("t2_c9_dmg", dmg_out, 11);
      chk("t2_c9_hp_p", hp_p, 89);
      chk("t2_c9_hp_a", hp_a, 78);

      // Saturating hit kills AI -> victory, then END ignores requests
      do_reset();
      run_hit(1'b0, 8'd20, 8'd20);
      chk("t3_dmg", dmg_out, 255);
      chk("t3_hp_a", hp_a, 0);
      chk("t3_victory", victory, 1);
      chk("t3_loss", loss, 0);
      chk("t3_zero", hp_is_zero, 1);
      req_a = 1'b1; atk_a = 8'd1; pow_a = 8'd1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_end_gnt_a", gnt_a, 0);
         chk("t3_end_busy", busy, 0);
         chk("t3_end_victory", victory, 1);
      end
      chk("t3_end_hp_p", hp_p, 100);
      req_a = 1'b0;

      // AI hits: 3*31+2 = 95 -> hp_p 5, then 11 -> clamps to 0
      do_reset();
      run_hit(1'b1, 8'd3, 8'd31);
      chk("t4_hp_p_5", hp_p, 5);
      chk("t4_loss_early", loss, 0);
      run_hit(1'b1, 8'd3, 8'd3);
      chk("t4_dmg", dmg_out, 11);
      chk("t4_hp_p_0", hp_p, 0);
      chk("t4_loss", loss, 1);
      chk("t4_victory", victory, 0);
      chk("t4_zero", hp_is_zero, 1);
      chk("t4_hp_a", hp_a, 100);

      // Reset during ADD aborts the hit
      do_reset();
      req_p = 1'b1; atk_p = 8'd5; pow_p = 8'd4;
      tick();
      req_p = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_hp_a", hp_a, 100);
      chk("t5_done", done, 0);
      chk("t5_busy", busy, 0);
      tick();
      chk("t5_done_after", done, 0);
      chk("t5_hp_a_after", hp_a, 100);
      run_hit(1'b0, 8'd5, 8'd4);
      chk("t5_dmg", dmg_out, 22);
      chk("t5_hp_a_final", hp_a, 78);

`ifdef PBS_CRIT_EN
      // Crit doubles (prod + bonus)
      do_reset();
      crit_p = 1'b1;
      run_hit(1'b0, 8'd5, 8'd4);
      chk("t6_crit_dmg", dmg_out, 44);
      chk("t6_crit_hp_a", hp_a, 56);
      crit_p = 1'b0;
      run_hit(1'b0, 8'd5, 8'd4);
      chk("t6_nocrit_dmg", dmg_out, 22);
      chk("t6_nocrit_hp_a", hp_a, 34);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
